// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

    localparam int unsigned DefaultN = 8;

    // Wide enough to hold 2N without wrapping.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(2 * n + 1);
    endfunction

    localparam int unsigned CntWidth = cnt_width(DefaultN);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StDrain,
        StRead,
        StFin
    } state_e;

endpackage

// File: rtl/systolic_sequencer_if.sv
// Operand input stream and result output stream of the sequencer.
interface systolic_sequencer_if
    import systolic_pkg::*;
#(
    parameter int unsigned N = DefaultN
) ();

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic [N-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/systolic_sequencer.sv
// Sequences one matrix job through an NxN systolic array: clear, load pairs,
// drain, shift results out.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    systolic_sequencer_if.slave stream,
    output logic                arr_reset,
    output logic                arr_readout,
    output logic [N-1:0]        arr_in1,
    output logic [N-1:0]        arr_in2,
    input  logic [N-1:0]        arr_out,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CntW = cnt_width(N);
    localparam logic [CntW-1:0] LoadLast  = CntW'(2 * N - 1);
    localparam logic [CntW-1:0] DrainLast = CntW'(2 * N - 1);
    localparam logic [CntW-1:0] ReadLast  = CntW'(N - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            aborted_q, aborted_d;
    logic [N-1:0]    buf_q, buf_d;
    logic [N-1:0]    in1_q, in1_d;
    logic [N-1:0]    in2_q, in2_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;
    logic            xfer;

    assign stream.in_ready  = (state_q == StLoad);
    assign xfer             = stream.in_valid & stream.in_ready;
    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_data_q;
    assign arr_reset        = ~rst_n | (state_q == StClear);
    assign arr_readout      = (state_q == StRead);
    assign arr_in1          = in1_q;
    assign arr_in2          = in2_q;
    assign busy             = (state_q != StIdle);
    assign done             = done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        aborted_d   = aborted_q;
        buf_d       = buf_q;
        in1_d       = '0;
        in2_d       = '0;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) state_d = StClear;
            end
            StClear: begin
                // An aborted job passes through CLEAR once and stops.
                state_d   = aborted_q ? StIdle : StLoad;
                aborted_d = 1'b0;
                buf_d     = '0;
            end
            StLoad: begin
                if (abort) begin
                    state_d   = StClear;
                    aborted_d = 1'b1;
                    buf_d     = '0;
                end else if (xfer) begin
                    if (!cnt_q[0]) begin
                        buf_d = stream.in_data;
                    end else begin
                        in1_d = buf_q;
                        in2_d = stream.in_data;
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LoadLast) state_d = StDrain;
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d   = StClear;
                    aborted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == DrainLast) state_d = StRead;
                end
            end
            StRead: begin
                if (abort) begin
                    state_d   = StClear;
                    aborted_d = 1'b1;
                end else begin
                    out_data_d  = arr_out;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + CntW'(1);
                    if (cnt_q == ReadLast) state_d = StFin;
                end
            end
            StFin: begin
                // done is registered, so the pulse trails FIN by one cycle.
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            aborted_q   <= 1'b0;
            buf_q       <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            aborted_q   <= aborted_d;
            buf_q       <= buf_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Randomized self-checking bench for systolic_sequencer with a behavioural array.
module tb_systolic_sequencer;
    import systolic_pkg::*;

    localparam int unsigned N = DefaultN;
    localparam int unsigned W = 2 * N;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         arr_reset, arr_readout, busy, done;
    logic [N-1:0] arr_in1, arr_in2, arr_out;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0] words [W];
    logic [N-1:0] rows  [N];

    systolic_sequencer_if #(.N(N)) stream ();

    systolic_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .stream     (stream),
        .arr_reset  (arr_reset),
        .arr_readout(arr_readout),
        .arr_in1    (arr_in1),
        .arr_in2    (arr_in2),
        .arr_out    (arr_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Stand-in array: each nonzero operand pair pushes in1&in2 into row 0,
    // readout shifts rows toward N-1, which drives arr_out.
    assign arr_out = rows[N-1];
    always @(posedge clk) begin
        if (arr_reset) begin
            for (int i = 0; i < N; i++) rows[i] <= '0;
        end else if (arr_readout) begin
            for (int i = N - 1; i > 0; i--) rows[i] <= rows[i-1];
            rows[0] <= '0;
        end else if ((arr_in1 | arr_in2) != '0) begin
            for (int i = N - 1; i > 0; i--) rows[i] <= rows[i-1];
            rows[0] <= arr_in1 & arr_in2;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected k-th result beat (k=0 first out, i.e. row N-1).
    function automatic logic [N-1:0] ref_beat(input int k);
        logic [N-1:0] pushed[$];
        int idx;
        for (int p = 0; p < N; p++) begin
            if ((words[2*p] | words[2*p+1]) != '0) pushed.push_back(words[2*p] & words[2*p+1]);
        end
        idx = pushed.size() - N + k;
        return (idx >= 0) ? pushed[idx] : '0;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < W; i++) words[i] = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
    endtask

    // gap: 0 back-to-back, 1 alternating idle/valid, 2 random.
    // abort_at: >0 aborts on that DRAIN cycle, -1 pulses abort during CLEAR.
    task automatic run_job(input int gap, input int abort_at, input bit start_in_drain);
        int           widx, last_acc, abort_c, done_c, n_done, pair_c, c;
        bit           in_load, v;
        logic [N-1:0] hold, exp1, exp2;
        logic [N-1:0] beats[$];
        int           beat_c[$];
        widx = 0; last_acc = -1; abort_c = -1; done_c = -1; n_done = 0; pair_c = -1;
        hold = '0; exp1 = '0; exp2 = '0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (c = 1; c <= 200; c++) begin
            in_load = (c >= 2) && (widx < W) && (abort_c < 0);
            stream.in_valid = 1'b0;
            stream.in_data  = '0;
            if (in_load) begin
                case (gap)
                    0:       v = 1'b1;
                    1:       v = (c % 2) == 1;
                    default: v = 1'($urandom % 2);
                endcase
                stream.in_valid = v;
                stream.in_data  = v ? words[widx] : N'($urandom);
            end
            if (abort_at == -1 && c == 1) abort = 1'b1;
            if (last_acc > 0 && abort_at > 0 && c == last_acc + abort_at) begin
                abort   = 1'b1;
                abort_c = c;
            end
            if (last_acc > 0 && start_in_drain && c == last_acc + 3) start = 1'b1;
            @(negedge clk);
            if (c == 1) begin
                check_eq("clear_arr_reset", arr_reset, 1);
                check_eq("clear_busy", busy, 1);
                check_eq("clear_in_ready", stream.in_ready, 0);
            end
            if (in_load) check_eq("load_in_ready", stream.in_ready, 1);
            check_eq("arr_in1", arr_in1, (c == pair_c) ? exp1 : '0);
            check_eq("arr_in2", arr_in2, (c == pair_c) ? exp2 : '0);
            if (abort_c > 0 && c == abort_c + 1) begin
                check_eq("abort_arr_reset", arr_reset, 1);
                check_eq("abort_busy", busy, 1);
            end
            if (abort_c > 0 && c == abort_c + 2) check_eq("abort_idle_busy", busy, 0);
            if (stream.out_valid) begin
                beats.push_back(stream.out_data);
                beat_c.push_back(c);
            end
            if (done) begin
                n_done++;
                if (done_c < 0) done_c = c;
                check_eq("busy_at_done", busy, 0);
            end
            if (in_load && stream.in_valid) begin
                if (widx % 2 == 0) begin
                    hold = words[widx];
                end else begin
                    exp1   = hold;
                    exp2   = words[widx];
                    pair_c = c + 1;
                end
                widx++;
                if (widx == W) last_acc = c;
            end
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            if (done_c > 0 && c >= done_c + 2) break;
            if (abort_c > 0 && c >= abort_c + 3 * N + 8) break;
        end
        stream.in_valid = 1'b0;
        if (abort_at > 0) begin
            check_eq("abort_beats", beats.size(), 0);
            check_eq("abort_done", n_done, 0);
        end else begin
            check_eq("done_count", n_done, 1);
            check_eq("beat_count", beats.size(), N);
            for (int k = 0; k < beats.size() && k < N; k++) check_eq("beat_data", beats[k], ref_beat(k));
            // Rise edge counted from the start edge: CLEAR + LOAD + DRAIN + READ + 1.
            check_eq("done_latency", done_c - 1, 1 + (last_acc - 1) + W + N + 1);
            if (beats.size() > 0) check_eq("done_after_beat", done_c, beat_c[beats.size()-1] + 1);
        end
    endtask

    initial begin
        stream.in_valid = 1'b0;
        stream.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_arr_reset", arr_reset, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_in_ready", stream.in_ready, 0);
        check_eq("rst_out_valid", stream.out_valid, 0);
        check_eq("rst_arr_in1", arr_in1, 0);
        check_eq("rst_readout", arr_readout, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_arr_reset", arr_reset, 0);

        // Single pair (1,1) then zeros; start pulse during DRAIN ignored.
        for (int i = 0; i < W; i++) words[i] = '0;
        words[0] = 8'h01;
        words[1] = 8'h01;
        run_job(0, 0, 1'b1);

        // All-ones operands with alternating gaps.
        for (int i = 0; i < W; i++) words[i] = '1;
        run_job(1, 0, 1'b0);

        // Abort on DRAIN cycle 5.
        fill_random();
        run_job(0, 5, 1'b0);

        // Abort during CLEAR is ignored.
        fill_random();
        run_job(0, -1, 1'b0);

        for (int j = 0; j < 4; j++) begin
            fill_random();
            run_job(j % 3, 0, 1'b0);
        end

        // Reset asserted mid-LOAD.
        fill_random();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        stream.in_valid = 1'b1;
        stream.in_data  = words[0];
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_arr_reset", arr_reset, 1);
        check_eq("midrst_in_ready", stream.in_ready, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_arr_in1", arr_in1, 0);
        stream.in_valid = 1'b0;
        begin
            int n_done = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (done) n_done++;
            end
            rst_n = 1'b1;
            for (int i = 0; i < 3 * W; i++) begin
                @(negedge clk);
                if (done) n_done++;
            end
            check_eq("midrst_no_done", n_done, 0);
            check_eq("midrst_idle_busy", busy, 0);
        end

        fill_random();
        run_job(0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 Parameter: N, default 8, meaning array dimension and operand word width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin one matrix job; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of the current job.
REQ-006 in_valid  input  1  operand word available.
REQ-007 in_ready  output  1  sequencer accepts an operand word this cycle.
REQ-008 in_data  input  N  operand word; the first word of each pair is in1, the second is in2.
REQ-009 arr_reset  output  1  clears all array cells.
REQ-010 arr_readout  output  1  switches the array to shift-out mode.
REQ-011 arr_in1, arr_in2  output  N each  operand edges driven into the array.
REQ-012 arr_out  input  N  array result edge.
REQ-013 out_valid / out_data  output  1 / N  result row beat; no backpressure.
REQ-014 busy / done  output  1 / 1  job in progress / one-cycle job-complete pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, CLEAR, LOAD, DRAIN, READ and FIN, all registered.
REQ-016 IDLE: start=1 SHALL move to CLEAR; all other inputs SHALL be ignored.
REQ-017 CLEAR: arr_reset=1 for exactly 1 cycle, then LOAD.
REQ-018 LOAD: in_ready=1; a word transfers when in_valid&in_ready; exactly 2N words SHALL be accepted, then DRAIN.
REQ-019 Pairing: an even-index word SHALL be latched in an in1 buffer; the following odd-index word SHALL drive arr_in1=buffer and arr_in2=in_data on the cycle after it is accepted, for 1 cycle only.
REQ-020 arr_in1/arr_in2 SHALL be 0 on every cycle not given by REQ-019, including in_valid gaps.
REQ-021 DRAIN: arr_in1/arr_in2=0 and arr_readout=0 for exactly 2N cycles, then READ.
REQ-022 READ: arr_readout=1 for exactly N cycles, then FIN.
REQ-023 After the k-th READ edge (k=1..N), arr_out SHALL be registered into out_data with out_valid=1 one cycle later; rows SHALL emerge last row (N-1) first and row 0 last.
REQ-024 FIN: done=1 for 1 cycle, then IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 abort=1 in LOAD, DRAIN or READ SHALL go to CLEAR next cycle; it SHALL discard the pair buffer and counters, suppress further out_valid beats and done, and end in IDLE rather than LOAD.
REQ-027 abort in IDLE, CLEAR or FIN SHALL be ignored; start while busy=1 SHALL be ignored.
REQ-028 Counters SHALL be clog2(2N+1) bits, SHALL reset at each state entry, and SHALL never wrap.

Reset
REQ-029 While rst_n=0: state=IDLE, arr_reset=1 (combinational from rst_n), and all other outputs, counters and buffers =0.
REQ-030 Deassertion of rst_n SHALL take effect on the first clk edge after it; assertion mid-job SHALL abandon the job with no done pulse.

Structure
REQ-031 Package systolic_pkg SHALL hold the state enumeration, the default N and the counter-width constant.
REQ-032 The design SHALL have no sub-module; the FSM, counters and pair buffer SHALL be in one module.

Verification (N=8)
REQ-033 Reset: rst_n low mid-LOAD -> same cycle arr_reset=1, in_ready=0, busy=0; no done pulse.
REQ-034 Single pair: word0=8'h01, word1=8'h01, 14 words of 8'h00 -> 8 out_valid beats; the last beat (row 0) =8'h01 and all other beats =8'h00; done exactly 1 cycle after the final beat.
REQ-035 Gapped input: in_valid toggling 1/0 -> LOAD lasts 32 cycles; arr_in1/arr_in2 nonzero only on the 8 pair cycles.
REQ-036 Timing: back-to-back words -> done rises 1 (CLEAR) + 16 (LOAD) + 16 (DRAIN) + 8 (READ) + 1 cycles after the start edge; a start pulse during DRAIN has no effect.
REQ-037 abort at DRAIN cycle 5 -> next cycle CLEAR (arr_reset=1), then IDLE; zero out_valid beats and no done.
REQ-038 All-ones operands: 16 words of 8'hFF -> all 8 out_data beats =8'hFF.
